// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arb_pkg;

  localparam int AW_DEF = 19;
  localparam int DW_DEF = 9;

  // Encoding of the controller's rw line.
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-port and controller-side bundles for sram_arbiter.
// sram_port_if: master = requester, slave = arbiter. sram_mem_if: master = arbiter, slave = sram_ctrl.
interface sram_port_if
  import sram_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  // req is a level held until ack; ack is a single-cycle completion pulse.
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input  ack, rdata);
  modport slave  (input  req, we, addr, wdata, output ack, rdata);
endinterface

interface sram_mem_if
  import sram_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  // A command transfers on a cycle where mem and ready are both high.
  logic          mem;
  logic          rw;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_f2s;
  logic          ready;
  logic [DW-1:0] data_s2f_r;

  modport master (output mem, rw, addr, data_f2s, input  ready, data_s2f_r);
  modport slave  (input  mem, rw, addr, data_f2s, output ready, data_s2f_r);
endinterface

// File: rtl/sram_arbiter_arb2_pick.sv
// Two-request winner select. SRAM_ARB_RR_EN selects round-robin ties;
// otherwise port 0 has fixed priority.
module arb2_pick (
  input  logic req0,
  input  logic req1,
  input  logic owner,
  output logic grant,
  output logic winner
);

  always_comb begin
    grant = req0 | req1;
`ifdef SRAM_ARB_RR_EN
    // On a tie the port that did not hold the last grant wins.
    if (req0 && req1) winner = ~owner;
    else              winner = req1;
`else
    winner = ~req0;
`endif
  end

`ifndef SRAM_ARB_RR_EN
  logic unused_owner;
  assign unused_owner = owner;
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Shares one sram_ctrl between two requesters, one command in flight at a time.
// Build option SRAM_ARB_RR_EN: round-robin tie-break instead of fixed port-0 priority.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic        clk,
  input  logic        reset,
  sram_port_if.slave  p0,
  sram_port_if.slave  p1,
  sram_mem_if.master  ctrl,
  output logic        busy,
  output logic        owner,
  output arb_state_t  dbg_state
);

  arb_state_t    state_q, state_d;
  logic          owner_q, owner_d;
  logic          busy_q, busy_d;
  logic          cmd_we_q, cmd_we_d;
  logic [AW-1:0] cmd_addr_q, cmd_addr_d;
  logic [DW-1:0] cmd_wdata_q, cmd_wdata_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;

  logic grant;
  logic winner;

  arb2_pick u_pick (
    .req0   (p0.req),
    .req1   (p1.req),
    .owner  (owner_q),
    .grant  (grant),
    .winner (winner)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;

    case (state_q)
      // Port inputs are only looked at here, so later changes cannot
      // disturb the command already latched.
      ARB: begin
        if (grant) begin
          owner_d     = winner;
          cmd_we_d    = winner ? p1.we    : p0.we;
          cmd_addr_d  = winner ? p1.addr  : p0.addr;
          cmd_wdata_d = winner ? p1.wdata : p0.wdata;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (ctrl.ready) state_d = BUSY;
      end
      BUSY: begin
        if (ctrl.ready) begin
          if (!cmd_we_q) begin
            if (owner_q) rdata1_d = ctrl.data_s2f_r;
            else         rdata0_d = ctrl.data_s2f_r;
          end
          ack0_d  = ~owner_q;
          ack1_d  = owner_q;
          state_d = DONE;
        end
      end
      // Requests are deliberately not sampled here so a requester can
      // drop or retarget req at the ack edge without a double issue.
      DONE: state_d = ARB;
      default: state_d = ARB;
    endcase

    busy_d = (state_d != ARB);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB;
      owner_q     <= 1'b1;
      busy_q      <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  // Controller side is decoded from registers only; addr/data hold between commands.
  assign ctrl.mem      = (state_q == ISSUE);
  assign ctrl.rw       = cmd_we_q ? RW_WRITE : RW_READ;
  assign ctrl.addr     = cmd_addr_q;
  assign ctrl.data_f2s = cmd_wdata_q;

  assign p0.ack   = ack0_q;
  assign p1.ack   = ack1_q;
  assign p0.rdata = rdata0_q;
  assign p1.rdata = rdata1_q;

  assign busy      = busy_q;
  assign owner     = owner_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter with a cycle-accurate sram_ctrl model.
// Honours SRAM_ARB_RR_EN when choosing expected grant order.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int AW = 19;
  localparam int DW = 9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sram_port_if #(.AW(AW), .DW(DW)) p0 ();
  sram_port_if #(.AW(AW), .DW(DW)) p1 ();
  sram_mem_if  #(.AW(AW), .DW(DW)) ctrl ();
  logic       busy;
  logic       owner;
  arb_state_t dbg_state;

  sram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .p0        (p0),
    .p1        (p1),
    .ctrl      (ctrl),
    .busy      (busy),
    .owner     (owner),
    .dbg_state (dbg_state)
  );

  // ---------------- sram_ctrl model ----------------
  typedef enum logic [2:0] {M_IDLE, M_RD1, M_RD2, M_WR1, M_WR2} m_state_t;
  m_state_t      m_st;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            hold_extra = 0;
  int            hold_cnt;
  logic [DW-1:0] sram_mem [logic [AW-1:0]];

  assign ctrl.ready = (m_st == M_IDLE) && (hold_cnt == 0);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_st            <= M_IDLE;
      hold_cnt        <= hold_extra;
      m_addr          <= '0;
      m_wdata         <= '0;
      ctrl.data_s2f_r <= '0;
    end else begin
      if (hold_cnt > 0) hold_cnt <= hold_cnt - 1;
      case (m_st)
        M_IDLE: if (ctrl.mem && ctrl.ready) begin
          m_addr  <= ctrl.addr;
          m_wdata <= ctrl.data_f2s;
          m_st    <= (ctrl.rw == RW_READ) ? M_RD1 : M_WR1;
        end
        M_RD1: m_st <= M_RD2;
        M_RD2: begin
          ctrl.data_s2f_r <= sram_mem.exists(m_addr) ? sram_mem[m_addr] : '0;
          m_st <= M_IDLE;
        end
        M_WR1: m_st <= M_WR2;
        M_WR2: begin
          sram_mem[m_addr] = m_wdata;
          m_st <= M_IDLE;
        end
        default: m_st <= M_IDLE;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int ack_cnt0 = 0;
  int ack_cnt1 = 0;
  int accept_cnt = 0;
  int mem_hi_cnt = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Every cycle of the run passes through here, so the event counters see each cycle once.
  task automatic tick();
    @(negedge clk);
    if (p0.ack) ack_cnt0++;
    if (p1.ack) ack_cnt1++;
    if (ctrl.mem && ctrl.ready) accept_cnt++;
    if (ctrl.mem) mem_hi_cnt++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_port(input int port, input logic rq, input logic we,
                            input logic [AW-1:0] a, input logic [DW-1:0] wd);
    if (port == 0) begin
      p0.req = rq; p0.we = we; p0.addr = a; p0.wdata = wd;
    end else begin
      p1.req = rq; p1.we = we; p1.addr = a; p1.wdata = wd;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " mem"},      ctrl.mem, 1'b0);
    check({tag, " rw"},       ctrl.rw, 1'b1);
    check({tag, " addr"},     ctrl.addr, '0);
    check({tag, " data_f2s"}, ctrl.data_f2s, '0);
    check({tag, " ack0"},     p0.ack, 1'b0);
    check({tag, " ack1"},     p1.ack, 1'b0);
    check({tag, " rdata0"},   p0.rdata, '0);
    check({tag, " rdata1"},   p1.rdata, '0);
    check({tag, " owner"},    owner, 1'b1);
    check({tag, " busy"},     busy, 1'b0);
    check({tag, " state"},    dbg_state, ARB);
  endtask

  task automatic do_reset(input int hold);
    hold_extra = hold;
    drive_port(0, 1'b0, 1'b0, '0, '0);
    drive_port(1, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_reset_state("reset");
  endtask

  // Runs one single-port transaction starting in an ARB cycle; ends in the following ARB cycle.
  task automatic txn(input int port, input logic we, input logic [AW-1:0] a,
                     input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd,
                     input int exp_lat, input string tag);
    int lat;
    int a0, a1, acc;
    bit got;
    logic [DW-1:0] exp_v;
    a0 = ack_cnt0; a1 = ack_cnt1; acc = accept_cnt;
    if (!we) exp_q.push_back(exp_rd);
    drive_port(port, 1'b1, we, a, wd);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      tick();
      lat++;
      if (lat == 1) begin
        check({tag, " issue mem"},  ctrl.mem, 1'b1);
        check({tag, " issue addr"}, ctrl.addr, a);
        check({tag, " issue rw"},   ctrl.rw, we ? RW_WRITE : RW_READ);
        if (we) check({tag, " issue data_f2s"}, ctrl.data_f2s, wd);
        check({tag, " issue busy"}, busy, 1'b1);
      end
      if (port == 0 ? p0.ack : p1.ack) got = 1'b1;
    end
    drive_port(port, 1'b0, we, a, wd);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " owner"}, owner, port[0]);
    if (!we) begin
      exp_v = exp_q.pop_front();
      check({tag, " rdata"}, port == 0 ? p0.rdata : p1.rdata, exp_v);
    end
    tick();
    check({tag, " ack width"}, port == 0 ? p0.ack : p1.ack, 1'b0);
    check({tag, " own acks"},   port == 0 ? ack_cnt0 - a0 : ack_cnt1 - a1, 1);
    check({tag, " other acks"}, port == 0 ? ack_cnt1 - a1 : ack_cnt0 - a0, 0);
    check({tag, " accepts"},    accept_cnt - acc, 1);
    check({tag, " idle busy"},  busy, 1'b0);
    check({tag, " idle state"}, dbg_state, ARB);
    if (we) check({tag, " sram content"}, sram_mem.exists(a) ? sram_mem[a] : '0, wd);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int            port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int order[4];
    int t_ack[4];
    int n, cyc, lat, a0, a1, mh;
    bit got;
    string nm;

    vecs[0] = '{1, 1'b1, 19'h12345, 9'h1A5, 9'h000};
    vecs[1] = '{0, 1'b0, 19'h12345, 9'h000, 9'h1A5};
    vecs[2] = '{0, 1'b1, 19'h00000, 9'h0FF, 9'h000};
    vecs[3] = '{1, 1'b0, 19'h00000, 9'h000, 9'h0FF};
    vecs[4] = '{1, 1'b1, 19'h7FFFF, 9'h1FF, 9'h000};
    vecs[5] = '{0, 1'b0, 19'h7FFFF, 9'h000, 9'h1FF};
    vecs[6] = '{1, 1'b0, 19'h12345, 9'h000, 9'h1A5};

    do_reset(0);

    for (int i = 0; i < 7; i++) begin
      nm = $sformatf("vec%0d", i);
      txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, 5, nm);
    end

    // Both ports requesting continuously for four grants.
    do_reset(0);
    a0 = ack_cnt0; a1 = ack_cnt1;
    for (int i = 0; i < 4; i++) begin order[i] = -1; t_ack[i] = 0; end
    drive_port(0, 1'b1, 1'b0, 19'h12345, '0);
    drive_port(1, 1'b1, 1'b0, 19'h12345, '0);
    n = 0; cyc = 0;
    while (n < 4 && cyc < 100) begin
      tick();
      cyc++;
      if (p0.ack || p1.ack) begin
        order[n] = p1.ack ? 1 : 0;
        t_ack[n] = cyc;
        check($sformatf("tie rdata %0d", n), p1.ack ? p1.rdata : p0.rdata, 9'h1A5);
        n++;
      end
    end
    drive_port(0, 1'b0, 1'b0, 19'h12345, '0);
    drive_port(1, 1'b0, 1'b0, 19'h12345, '0);
    tick();
    check("tie first ack cycle", t_ack[0], 5);
    for (int i = 0; i < 4; i++) begin
`ifdef SRAM_ARB_RR_EN
      check($sformatf("tie order %0d", i), order[i], i % 2);
`else
      check($sformatf("tie order %0d", i), order[i], 0);
`endif
      if (i > 0) check($sformatf("tie spacing %0d", i), t_ack[i] - t_ack[i-1], 6);
    end
`ifdef SRAM_ARB_RR_EN
    check("tie p0 acks", ack_cnt0 - a0, 2);
    check("tie p1 acks", ack_cnt1 - a1, 2);
`else
    check("tie p0 acks", ack_cnt0 - a0, 4);
    check("tie p1 acks", ack_cnt1 - a1, 0);
`endif

    // Port 0 retargets addr mid-command; the latched address must stay on the bus.
    drive_port(0, 1'b1, 1'b0, 19'h7FFFF, '0);
    lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      tick();
      lat++;
      if (lat == 2) p0.addr = 19'h12345;
      if (lat == 3 || lat == 4) check($sformatf("hold addr c%0d", lat), ctrl.addr, 19'h7FFFF);
      if (p0.ack) got = 1'b1;
    end
    p0.req = 1'b0;
    check("chg latency", lat, 5);
    check("chg rdata", p0.rdata, 9'h1FF);
    tick();
    txn(0, 1'b0, 19'h12345, '0, 9'h1A5, 5, "after chg");

    // Reset in cycle 3 of a port-0 read; req stays high across it.
    a0 = ack_cnt0;
    drive_port(0, 1'b1, 1'b0, 19'h12345, '0);
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    check("rst mem", ctrl.mem, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst state", dbg_state, ARB);
    check("rst ack0", p0.ack, 1'b0);
    tick();
    reset = 1'b0;
    check("rst no ack", ack_cnt0 - a0, 0);
    lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      tick();
      lat++;
      if (p0.ack) got = 1'b1;
    end
    p0.req = 1'b0;
    check("rst reissue latency", lat, 5);
    check("rst reissue rdata", p0.rdata, 9'h1A5);
    tick();

    // Controller stays not-ready for a while after reset.
    do_reset(3);
    mh = mem_hi_cnt;
    txn(0, 1'b0, 19'h7FFFF, '0, 9'h1FF, 7, "hold");
    check("hold mem cycles", mem_hi_cnt - mh, 3);
    hold_extra = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter that shares the single SRAM controller (`sram_ctrl`) between two independent requesters, for example a CPU/bus port and a video/DMA port. It arbitrates pending requests and issues one command at a time on the controller's `mem`/`rw` handshake. It waits for the controller to return to ready, captures read data, and acknowledges the owning port. It sits between the system masters and `sram_ctrl`; the SRAM chip pins are untouched.

## Interface
Parameters:
- `AW`, default 19: address width; matches the controller address.
- `DW`, default 9: data width; matches the controller data path.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high.
- `pN_req`, in, 1 (N = 0, 1): request level; held high until `pN_ack`.
- `pN_we`, in, 1: 1 = write, 0 = read.
- `pN_addr`, in, `AW`: word address.
- `pN_wdata`, in, `DW`: write data.
- `pN_ack`, out, 1: one-cycle completion pulse.
- `pN_rdata`, out, `DW`: read data; valid while `pN_ack` is high, held until the next read on that port.
- `mem`, out, 1: command strobe to the controller.
- `rw`, out, 1: 1 = read, 0 = write, to the controller.
- `addr`, out, `AW`: address to the controller.
- `data_f2s`, out, `DW`: write data to the controller.
- `ready`, in, 1: controller idle/ready.
- `data_s2f_r`, in, `DW`: registered read data from the controller.
- `busy`, out, 1: high in every state except ARB.
- `owner`, out, 1: port index of the current or last grant.

## Operation
State machine, with exactly one command in flight:
- ARB:
  - Sample `p0_req` and `p1_req`.
  - If any request is pending, pick a winner and latch its `we`, `addr` and `wdata` into command registers.
  - Set `owner` to the winner and go to ISSUE.
  - With no request pending, stay in ARB.
- ISSUE:
  - Drive `mem`=1, `rw`=~we, and `addr`/`data_f2s` from the command registers.
  - If `ready`=1, the command is accepted; go to BUSY.
  - If `ready`=0, hold `mem` high and stay in ISSUE.
- BUSY:
  - `mem`=0; wait for `ready`=1.
  - On `ready`=1, for a read, load `data_s2f_r` into `p<owner>_rdata`.
  - Go to DONE.
- DONE:
  - `p<owner>_ack`=1 for this cycle only; return to ARB.
  - Requests are not sampled in DONE, so the requester updates `req`/`addr` at the ack edge without being double-issued.

Other rules:
- Port inputs are ignored outside ARB. Changing them after the grant has no effect on the command in flight.
- `addr`/`data_f2s` hold their last value whenever `mem`=0.
- Reset values:
  - State ARB; `mem`=0, `rw`=1, `addr`=0, `data_f2s`=0.
  - Both acks 0, both `rdata` 0; `owner`=1, so port 0 wins the first tie; `busy`=0.
- Reset mid-operation returns to ARB with no ack. The controller shares `reset` and aborts too. The interrupted requester re-issues because its `req` is still high.

## Timing
Cycle 0 is the ARB cycle that sees `req`.

- Cycle 1: ISSUE; `mem`=1 and the controller accepts.
- Cycles 2–3: BUSY; `ready`=0 (controller rd1/rd2 or wr1/wr2).
- Cycle 4: BUSY; `ready`=1; read data captured.
- Cycle 5: DONE; `ack`=1 and `rdata` valid.
- Cycle 6: ARB again.
- Throughput: one access per 6 cycles. Latency from `req` to `ack` is 5 cycles for both read and write.
- All outputs are registered except `mem`, `rw`, `addr` and `data_f2s`. Those are decoded from the state and command registers, so they carry no combinational path from the port inputs.

## Configuration
- `SRAM_ARB_RR_EN` defined: round-robin arbitration.
  - On a tie, grant the port that is not `owner`.
  - A single requester is granted regardless of `owner`.
  - Two continuously requesting ports strictly alternate.
- Undefined: fixed priority; port 0 always wins a tie, and port 1 may starve.

## Structure
- Package `sram_arb_pkg` holds:
  - the state enum (ARB, ISSUE, BUSY, DONE);
  - `AW`/`DW` default constants;
  - the read/write encoding constants (`RW_READ`=1, `RW_WRITE`=0).
- Sub-module `arb2_pick`: combinational two-request winner select, taking the `owner` input and the `SRAM_ARB_RR_EN` behaviour. The top level holds the FSM, the command registers and the per-port `rdata` registers.

## Test plan
All scenarios use a `sram_ctrl`-accurate behavioural model.

- Port 1 write: addr 0x12345, data 0x1A5. Then port 0 read of 0x12345 → `p0_rdata`=0x1A5 with `p0_ack` at cycle 5; `p1_ack` pulses exactly once.
- Both ports raise `req` in the same cycle with `RR_EN`, held for 4 transactions → grant order 0,1,0,1; each ack is one cycle, spaced 6 cycles apart.
- Same stimulus without `RR_EN` → four consecutive port-0 grants; `p1_ack` stays 0.
- Port 0 changes `addr` during BUSY → SRAM `addr` holds the latched value, and the next command uses the new one.
- `reset` asserted in cycle 3 of a port-0 read → `mem`=0, no ack, state ARB. After release, the read re-issues and completes 5 cycles later.
- Model holds `ready`=0 for 3 extra cycles after reset → ISSUE keeps `mem`=1 until `ready`; exactly one command is accepted.
